// File: rtl/reg_dump_streamer.sv
// Streams the architectural register file out as indexed records once per reset, after halt or a cycle limit.
// Define REG_DUMP_CHECKSUM_EN to append a running-sum record (index 32) after the last register.
module reg_dump_streamer #(
    parameter int NUM_REGS    = 32,
    parameter int CYCLE_LIMIT = 400
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        halt_i,
    output logic [4:0]  rf_raddr_o,
    input  logic [31:0] rf_rdata_i,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [5:0]  out_idx,
    output logic [31:0] out_data,
    output logic        out_last,
    output logic        busy_o,
    output logic        done_o,
    output logic [31:0] cycle_cnt_o
);

    typedef enum logic [2:0] {
        IDLE,
        READ,
        WAIT,
        SEND,
        DONE
    } state_t;

    localparam logic [5:0]  LAST_IDX     = 6'(NUM_REGS - 1);
    localparam logic [5:0]  CHECKSUM_IDX = 6'd32;
    localparam logic [31:0] LIMIT_M1     = (CYCLE_LIMIT == 0) ? 32'd0 : 32'(CYCLE_LIMIT - 1);

    state_t      r_state;
    state_t      w_nextState;
    logic [5:0]  r_idx;
    logic [31:0] r_cycleCnt;
    logic [5:0]  r_outIdx;
    logic [31:0] r_outData;
    logic        r_outLast;
`ifdef REG_DUMP_CHECKSUM_EN
    logic [31:0] r_sum;
`endif

    logic        w_trigger;
    logic        w_handshake;
    logic        w_isLastReg;
    logic [31:0] w_regData;

    assign w_trigger   = halt_i || ((CYCLE_LIMIT != 0) && (r_cycleCnt == LIMIT_M1));
    assign w_handshake = (r_state == SEND) && out_ready;
    assign w_isLastReg = (r_idx == LAST_IDX);
    // x0 is hardwired zero architecturally, whatever the storage holds
    assign w_regData   = (r_idx == 6'd0) ? 32'd0 : rf_rdata_i;

    always_comb begin
        w_nextState = r_state;
        unique case (r_state)
            IDLE: if (w_trigger) w_nextState = READ;
            READ: w_nextState = WAIT;
            WAIT: w_nextState = SEND;
            SEND: begin
                if (w_handshake) begin
                    if (r_outLast) begin
                        w_nextState = DONE;
                    end else begin
`ifdef REG_DUMP_CHECKSUM_EN
                        // the checksum record needs no regfile read, so stay in SEND
                        w_nextState = w_isLastReg ? SEND : READ;
`else
                        w_nextState = READ;
`endif
                    end
                end
            end
            DONE: w_nextState = DONE;
            default: w_nextState = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= IDLE;
            r_idx      <= 6'd0;
            r_cycleCnt <= 32'd0;
            r_outIdx   <= 6'd0;
            r_outData  <= 32'd0;
            r_outLast  <= 1'b0;
`ifdef REG_DUMP_CHECKSUM_EN
            r_sum      <= 32'd0;
`endif
        end else begin
            r_state <= w_nextState;
            if ((r_state == IDLE) && (r_cycleCnt != 32'hFFFF_FFFF)) begin
                r_cycleCnt <= r_cycleCnt + 32'd1;
            end
            unique case (r_state)
                WAIT: begin
                    r_outIdx  <= r_idx;
                    r_outData <= w_regData;
`ifdef REG_DUMP_CHECKSUM_EN
                    r_outLast <= 1'b0;
                    r_sum     <= r_sum + w_regData;
`else
                    r_outLast <= w_isLastReg;
`endif
                end
                SEND: begin
                    if (w_handshake && !r_outLast) begin
`ifdef REG_DUMP_CHECKSUM_EN
                        if (w_isLastReg) begin
                            r_outIdx  <= CHECKSUM_IDX;
                            r_outData <= r_sum;
                            r_outLast <= 1'b1;
                        end else begin
                            r_idx <= r_idx + 6'd1;
                        end
`else
                        r_idx <= r_idx + 6'd1;
`endif
                    end
                end
                default: ;
            endcase
        end
    end

    assign rf_raddr_o  = r_idx[4:0];
    assign out_valid   = (r_state == SEND);
    assign out_idx     = r_outIdx;
    assign out_data    = r_outData;
    assign out_last    = r_outLast;
    assign busy_o      = (r_state == READ) || (r_state == WAIT) || (r_state == SEND);
    assign done_o      = (r_state == DONE);
    assign cycle_cnt_o = r_cycleCnt;

endmodule

// File: tb/tb_reg_dump_streamer.sv
// Directed bench for reg_dump_streamer: expected records are queued at trigger time and popped on each handshake.
// Build with REG_DUMP_CHECKSUM_EN defined to also expect the trailing checksum record.
module tb_reg_dump_streamer;

    localparam int NUM_REGS    = 32;
    localparam int CYCLE_LIMIT = 400;

    typedef struct packed {
        logic [5:0]  idx;
        logic [31:0] data;
        logic        last;
    } rec_t;

    logic        clk;
    logic        reset;
    logic        halt_i;
    logic [4:0]  rf_raddr_o;
    logic [31:0] rf_rdata_i;
    logic        out_valid;
    logic        out_ready;
    logic [5:0]  out_idx;
    logic [31:0] out_data;
    logic        out_last;
    logic        busy_o;
    logic        done_o;
    logic [31:0] cycle_cnt_o;

    rec_t expQ[$];
    int   checks = 0;
    int   errors = 0;
    int   rfMode = 0;

    reg_dump_streamer #(
        .NUM_REGS    (NUM_REGS),
        .CYCLE_LIMIT (CYCLE_LIMIT)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .halt_i      (halt_i),
        .rf_raddr_o  (rf_raddr_o),
        .rf_rdata_i  (rf_rdata_i),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_idx     (out_idx),
        .out_data    (out_data),
        .out_last    (out_last),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .cycle_cnt_o (cycle_cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // x0 storage deliberately holds garbage so the forced-zero path is exercised
    function automatic logic [31:0] regVal(input logic [4:0] a);
        if (a == 5'd0) return 32'hDEAD_BEEF;
        if (rfMode == 1) return 32'hFFFF_FFFF;
        return 32'(a) * 32'h11;
    endfunction

    // Synchronous-read register file: data valid one cycle after the address
    always @(posedge clk) rf_rdata_i <= regVal(rf_raddr_o);

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic rst, input logic halt);
        @(negedge clk);
        reset  = rst;
        halt_i = halt;
    endtask

    task automatic pushDump();
        logic [31:0] sum;
        rec_t        r;
        sum = 32'd0;
        for (int i = 0; i < NUM_REGS; i++) begin
            r.idx  = 6'(i);
            r.data = (i == 0) ? 32'd0 : regVal(5'(i));
`ifdef REG_DUMP_CHECKSUM_EN
            r.last = 1'b0;
`else
            r.last = (i == NUM_REGS - 1);
`endif
            sum = sum + r.data;
            expQ.push_back(r);
        end
`ifdef REG_DUMP_CHECKSUM_EN
        r.idx  = 6'd32;
        r.data = sum;
        r.last = 1'b1;
        expQ.push_back(r);
`endif
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_valid"}, 32'(out_valid), 32'd0);
        checkOutput({tag, "_busy"},  32'(busy_o), 32'd0);
        checkOutput({tag, "_done"},  32'(done_o), 32'd0);
        checkOutput({tag, "_idx"},   32'(out_idx), 32'd0);
        checkOutput({tag, "_data"},  out_data, 32'd0);
        checkOutput({tag, "_last"},  32'(out_last), 32'd0);
        checkOutput({tag, "_raddr"}, 32'(rf_raddr_o), 32'd0);
        checkOutput({tag, "_cnt"},   cycle_cnt_o, 32'd0);
    endtask

    // Holds reset for two edges, checks reset values, then releases on a falling edge
    task automatic resetAndCheck(input string tag);
        out_ready = 1'b0;
        applyStimulus(1'b1, 1'b0);
        applyStimulus(1'b1, 1'b0);
        checkResetOutputs(tag);
        expQ.delete();
        applyStimulus(1'b0, 1'b0);
    endtask

    // mode 0: always ready; mode 1: ready one cycle in three. stopIdx>=0 returns with that record pending.
    task automatic drainDump(input int mode, input int stopIdx, input int budget);
        int   cyc;
        bit   held;
        bit   finished;
        rec_t heldRec;
        rec_t exp;
        cyc      = 0;
        held     = 1'b0;
        finished = 1'b0;
        while (!finished && cyc < budget) begin
            @(negedge clk);
            cyc++;
            if (out_valid && held) begin
                checkOutput("stall_idx",  32'(out_idx),  32'(heldRec.idx));
                checkOutput("stall_data", out_data,      heldRec.data);
                checkOutput("stall_last", 32'(out_last), 32'(heldRec.last));
            end
            if (out_valid && stopIdx >= 0 && int'(out_idx) == stopIdx) begin
                out_ready = 1'b0;
                finished  = 1'b1;
            end else begin
                out_ready = (mode == 0) ? 1'b1 : ((cyc % 3) == 0);
                if (out_valid && out_ready) begin
                    held = 1'b0;
                    if (expQ.size() == 0) begin
                        checkOutput("extra_record", 32'(out_idx), 32'hFFFF_FFFF);
                        finished = 1'b1;
                    end else begin
                        exp = expQ.pop_front();
                        checkOutput("rec_idx",  32'(out_idx),  32'(exp.idx));
                        checkOutput("rec_data", out_data,      exp.data);
                        checkOutput("rec_last", 32'(out_last), 32'(exp.last));
                        if (expQ.size() == 0) finished = 1'b1;
                    end
                end else if (out_valid) begin
                    held         = 1'b1;
                    heldRec.idx  = out_idx;
                    heldRec.data = out_data;
                    heldRec.last = out_last;
                end
            end
        end
        checkOutput("drain_timeout", 32'(finished), 32'd1);
    endtask

    task automatic checkDone(input string tag);
        @(negedge clk);
        checkOutput({tag, "_done"},  32'(done_o), 32'd1);
        checkOutput({tag, "_busy"},  32'(busy_o), 32'd0);
        checkOutput({tag, "_valid"}, 32'(out_valid), 32'd0);
        checkOutput({tag, "_left"},  32'(expQ.size()), 32'd0);
    endtask

    initial begin
        int          cyc;
        logic [31:0] frozen;
        reset     = 1'b1;
        halt_i    = 1'b0;
        out_ready = 1'b0;

        // Auto-trigger from the cycle limit, consumer always ready
        $display("[TB] auto-trigger dump");
        rfMode = 0;
        resetAndCheck("rst0");
        pushDump();
        cyc = 0;
        while (!out_valid && cyc < 1000) begin
            @(negedge clk);
            cyc++;
        end
        checkOutput("auto_first_valid_cycle", 32'(cyc), 32'(CYCLE_LIMIT + 2));
        checkOutput("auto_cnt_frozen", cycle_cnt_o, 32'(CYCLE_LIMIT));
        checkOutput("auto_busy", 32'(busy_o), 32'd1);
        drainDump(0, -1, 400);
        checkDone("auto");

        // Halt pulse when the counter reads 10
        $display("[TB] halt pulse dump");
        resetAndCheck("rst1");
        cyc = 0;
        while (cycle_cnt_o != 32'd10 && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        checkOutput("halt_cnt_reached", cycle_cnt_o, 32'd10);
        halt_i = 1'b1;
        pushDump();
        @(negedge clk);
        halt_i = 1'b0;
        frozen = cycle_cnt_o;
        checkOutput("halt_cnt_range", 32'(frozen >= 32'd10 && frozen <= 32'd11), 32'd1);
        checkOutput("halt_busy", 32'(busy_o), 32'd1);
        drainDump(0, -1, 400);
        checkDone("halt");
        checkOutput("halt_cnt_still_frozen", cycle_cnt_o, frozen);

        // Back-pressure: ready one cycle in three, alternate data pattern
        $display("[TB] stalled consumer dump");
        rfMode = 1;
        resetAndCheck("rst2");
        halt_i = 1'b1;
        pushDump();
        @(negedge clk);
        halt_i = 1'b0;
        drainDump(1, -1, 1000);
        checkDone("stall");

        // Reset while record 12 is pending, then a fresh dump
        $display("[TB] abort mid-dump");
        rfMode = 0;
        resetAndCheck("rst3");
        halt_i = 1'b1;
        pushDump();
        @(negedge clk);
        halt_i = 1'b0;
        drainDump(0, 12, 200);
        checkOutput("abort_pending_idx", 32'(out_idx), 32'd12);
        reset = 1'b1;
        @(negedge clk);
        checkResetOutputs("abort");
        expQ.delete();
        applyStimulus(1'b0, 1'b0);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            checkOutput("abort_quiet_valid", 32'(out_valid), 32'd0);
        end
        halt_i = 1'b1;
        pushDump();
        @(negedge clk);
        halt_i = 1'b0;
        drainDump(0, -1, 400);
        checkDone("restart");

        // Halt held high throughout: exactly one dump
        $display("[TB] halt held high");
        resetAndCheck("rst4");
        halt_i = 1'b1;
        pushDump();
        drainDump(0, -1, 400);
        checkDone("held");
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            checkOutput("held_no_redump", 32'(out_valid), 32'd0);
            checkOutput("held_done_sticky", 32'(done_o), 32'd1);
        end
        halt_i = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
